// File: rtl/wb_ifetch_prefetch.sv
// Instruction prefetcher: single-word Wishbone reads at consecutive addresses into a small FIFO.
// Bus states: B_IDLE | no read outstanding ; B_REQ | one read outstanding, stb/cyc/adr held until ack.
module wb_ifetch_prefetch #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {B_IDLE, B_REQ} bus_state_t;
    bus_state_t state_q, state_d;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, count_eff;
    logic             stale_q, stale_d;
    logic [WA_W-1:0]  head_q, head_d, pf_q, pf_d, adr_q, adr_d, pf_eff;
    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;

    logic [WA_W-1:0]  fetch_word;
    logic             inflight, req_seen, hit, miss, ack_seen, push;
    logic             unused_addr_bits;

    assign fetch_word       = fetch_addr_i[ADDR_W-1:2];
    assign unused_addr_bits = ^{fetch_addr_i[31:ADDR_W], fetch_addr_i[1:0]};
    assign inflight         = (state_q == B_REQ);
    assign req_seen         = fetch_req_i && !valid_q;
    assign hit              = req_seen && (count_q != '0) && (fetch_word == head_q);
    assign miss             = req_seen && (fetch_word != head_q);
    assign ack_seen         = ack_i && inflight;
    // A miss in the same cycle as an ack drops the acked word outright.
    assign push             = ack_seen && !stale_q && !miss;
    assign count_eff        = miss ? '0 : count_q;
    assign pf_eff           = miss ? fetch_word : pf_q;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stale_d  = stale_q;
        head_d   = head_q;
        pf_d     = pf_q;
        adr_d    = adr_q;
        valid_d  = hit;
        instr_d  = instr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (hit) begin
            instr_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            head_d   = head_q + WA_W'(1);
        end
        if (push && !hit) begin
            count_d = count_q + CNT_W'(1);
        end else if (hit && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (miss) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            head_d   = fetch_word;
            pf_d     = fetch_word;
            stale_d  = inflight && !ack_i;
        end else if (ack_seen) begin
            stale_d = 1'b0;
        end

        case (state_q)
            B_IDLE: begin
                if (count_eff < CNT_W'(DEPTH)) begin
                    state_d = B_REQ;
                    adr_d   = pf_eff;
                    pf_d    = pf_eff + WA_W'(1);
                end
            end
            B_REQ: begin
                if (ack_i) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= B_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stale_q  <= 1'b0;
            head_q   <= '0;
            pf_q     <= '0;
            adr_q    <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stale_q  <= stale_d;
            head_q   <= head_d;
            pf_q     <= pf_d;
            adr_q    <= adr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    assign fetch_valid_o = valid_q;
    assign fetch_instr_o = instr_q;
    assign adr_o         = {{(32-ADDR_W){1'b0}}, adr_q, 2'b00};
    assign dat_o         = '0;
    assign we_o          = 1'b0;
    assign sel_o         = 4'hF;
    assign stb_o         = inflight;
    assign cyc_o         = inflight;

endmodule

// File: tb/tb_wb_ifetch_prefetch.sv
// Directed bench for wb_ifetch_prefetch: table of streamed fetches against a short-latency
// slave model, then cycle-exact sequences for hit/refill, pop+ack, redirect and reset.
module tb_wb_ifetch_prefetch;
    logic        clk;
    logic        rst;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;
    logic [31:0] dat_i;

    wb_ifetch_prefetch #(.DEPTH(2), .ADDR_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req_i  (fetch_req_i),
        .fetch_addr_i (fetch_addr_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_instr_o(fetch_instr_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .we_o         (we_o),
        .sel_o        (sel_o),
        .stb_o        (stb_o),
        .cyc_o        (cyc_o),
        .ack_i        (ack_i),
        .dat_i        (dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_adr;
        logic [31:0] exp_instr;
        bit          first;
    } row_t;

    row_t        tbl [11];
    int          checks;
    int          failures;
    bit          auto_slave;
    bit          sl_busy;
    int          sl_cnt;
    logic [31:0] sl_adr;
    int          hi_bad;
    logic [31:0] adr_log [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA500_0000 ^ a ^ (a << 12);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // One cycle; in auto mode also runs the slave (acks 3 cycles after stb is seen).
    task automatic tick();
        @(negedge clk);
        if (auto_slave) begin
            ack_i = 1'b0;
            if (sl_busy) begin
                if (sl_cnt == 0) begin
                    ack_i   = 1'b1;
                    dat_i   = word_of(sl_adr);
                    sl_busy = 1'b0;
                end else begin
                    sl_cnt--;
                end
            end else if (stb_o) begin
                sl_busy = 1'b1;
                sl_adr  = adr_o;
                sl_cnt  = 2;
                adr_log.push_back(adr_o);
                if (adr_o[31:24] != 8'h00) hi_bad++;
            end
        end
    endtask

    task automatic wait_quiet();
        repeat (40) tick();
        chk1("quiet_full_no_req", stb_o, 1'b0);
    endtask

    task automatic fetch_auto(input int r);
        bit got;
        got          = 1'b0;
        fetch_req_i  = 1'b1;
        fetch_addr_i = tbl[r].addr;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (fetch_valid_o) got = 1'b1;
        end
        fetch_req_i = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL row%0d_valid: no fetch_valid_o within 400 cycles, expected instr %08h",
                     r, tbl[r].exp_instr);
        end else begin
            chk($sformatf("row%0d_instr", r), fetch_instr_o, tbl[r].exp_instr);
        end
    endtask

    initial begin
        int k;
        checks       = 0;
        failures     = 0;
        hi_bad       = 0;
        sl_busy      = 1'b0;
        sl_cnt       = 0;
        sl_adr       = '0;
        auto_slave   = 1'b1;
        rst          = 1'b1;
        fetch_req_i  = 1'b0;
        fetch_addr_i = '0;
        ack_i        = 1'b0;
        dat_i        = '0;

        tbl[0]  = '{32'h0000_0100, 32'h0000_0100, word_of(32'h0000_0100), 1'b1};
        tbl[1]  = '{32'h0000_0104, 32'h0000_0104, word_of(32'h0000_0104), 1'b0};
        tbl[2]  = '{32'h0000_0108, 32'h0000_0108, word_of(32'h0000_0108), 1'b0};
        tbl[3]  = '{32'h0000_010C, 32'h0000_010C, word_of(32'h0000_010C), 1'b0};
        tbl[4]  = '{32'h00FF_FFF8, 32'h00FF_FFF8, word_of(32'h00FF_FFF8), 1'b1};
        tbl[5]  = '{32'h00FF_FFFC, 32'h00FF_FFFC, word_of(32'h00FF_FFFC), 1'b0};
        tbl[6]  = '{32'h0000_0000, 32'h0000_0000, word_of(32'h0000_0000), 1'b0};
        tbl[7]  = '{32'h0000_0004, 32'h0000_0004, word_of(32'h0000_0004), 1'b0};
        tbl[8]  = '{32'h0000_ABC0, 32'h0000_ABC0, word_of(32'h0000_ABC0), 1'b1};
        tbl[9]  = '{32'h0000_ABC5, 32'h0000_ABC4, word_of(32'h0000_ABC4), 1'b0};
        tbl[10] = '{32'hFF00_ABC8, 32'h0000_ABC8, word_of(32'h0000_ABC8), 1'b0};

        tick();
        tick();
        chk1("rst_stb", stb_o, 1'b0);
        chk1("rst_cyc", cyc_o, 1'b0);
        chk1("rst_valid", fetch_valid_o, 1'b0);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_instr", fetch_instr_o, 32'h0);
        chk("const_dat_o", dat_o, 32'h0);
        chk1("const_we_o", we_o, 1'b0);
        chk("const_sel_o", {28'h0, sel_o}, 32'hF);
        rst = 1'b0;

        k = 0;
        for (int r = 0; r < 11; r++) begin
            if (tbl[r].first) begin
                wait_quiet();
                adr_log.delete();
                k = 0;
            end
            fetch_auto(r);
            if (adr_log.size() > k) begin
                chk($sformatf("row%0d_adr", r), adr_log[k], tbl[r].exp_adr);
            end else begin
                checks++;
                failures++;
                $display("FAIL row%0d_adr: no bus request logged, expected %08h", r, tbl[r].exp_adr);
            end
            k++;
        end

        wait_quiet();
        auto_slave = 1'b0;
        ack_i      = 1'b0;

        // Miss from idle, fill to full, hit with refill.
        fetch_req_i = 1'b1; fetch_addr_i = 32'h200;
        tick();
        chk1("t2_miss_stb", stb_o, 1'b1);
        chk("t2_miss_adr", adr_o, 32'h200);
        fetch_req_i = 1'b0; ack_i = 1'b1; dat_i = word_of(32'h200);
        tick();
        ack_i = 1'b0;
        chk1("t2_gap_after_ack", stb_o, 1'b0);
        tick();
        chk("t2_second_adr", adr_o, 32'h204);
        ack_i = 1'b1; dat_i = word_of(32'h204);
        tick();
        ack_i = 1'b0;
        tick();
        chk1("t2_full_no_req", stb_o, 1'b0);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h200;
        tick();
        chk1("t2_hit_valid", fetch_valid_o, 1'b1);
        chk("t2_hit_instr", fetch_instr_o, word_of(32'h200));
        fetch_req_i = 1'b0;
        tick();
        chk1("t2_refill_stb", stb_o, 1'b1);
        chk("t2_refill_adr", adr_o, 32'h208);

        // Pop and ack in the same cycle.
        ack_i = 1'b1; dat_i = word_of(32'h208);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h204;
        tick();
        chk1("t5_pop_valid", fetch_valid_o, 1'b1);
        chk("t5_pop_instr", fetch_instr_o, word_of(32'h204));
        ack_i = 1'b0; fetch_req_i = 1'b0;
        tick();
        chk("t5_next_adr", adr_o, 32'h20C);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h208;
        tick();
        chk1("t5_order_valid", fetch_valid_o, 1'b1);
        chk("t5_order_instr", fetch_instr_o, word_of(32'h208));
        fetch_req_i = 1'b0;

        // Redirect while 0x20C is in flight.
        tick();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h400;
        tick();
        chk1("t3_miss_novalid", fetch_valid_o, 1'b0);
        chk("t3_hold_adr", adr_o, 32'h20C);
        ack_i = 1'b1; dat_i = word_of(32'h20C);
        tick();
        ack_i = 1'b0;
        chk1("t3_gap", stb_o, 1'b0);
        tick();
        chk1("t3_stale_dropped", fetch_valid_o, 1'b0);
        chk1("t3_new_stb", stb_o, 1'b1);
        chk("t3_new_adr", adr_o, 32'h400);
        ack_i = 1'b1; dat_i = word_of(32'h400);
        tick();
        ack_i = 1'b0;
        tick();
        chk1("t3_new_valid", fetch_valid_o, 1'b1);
        chk("t3_new_instr", fetch_instr_o, word_of(32'h400));
        chk("t3_follow_adr", adr_o, 32'h404);
        fetch_req_i = 1'b0;

        // Miss and ack in the same cycle.
        tick();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h600;
        ack_i = 1'b1; dat_i = word_of(32'h404);
        tick();
        ack_i = 1'b0;
        chk1("tm_gap", stb_o, 1'b0);
        chk1("tm_novalid", fetch_valid_o, 1'b0);
        tick();
        chk1("tm_next_stb", stb_o, 1'b1);
        chk("tm_next_adr", adr_o, 32'h600);
        ack_i = 1'b1; dat_i = word_of(32'h600);
        tick();
        ack_i = 1'b0;
        tick();
        chk1("tm_valid", fetch_valid_o, 1'b1);
        chk("tm_instr", fetch_instr_o, word_of(32'h600));
        chk1("tm_follow_stb", stb_o, 1'b1);
        fetch_req_i = 1'b0;

        // Reset during B_REQ, then a stray ack while idle.
        rst = 1'b1;
        tick();
        chk1("t6_stb", stb_o, 1'b0);
        chk1("t6_cyc", cyc_o, 1'b0);
        chk1("t6_valid", fetch_valid_o, 1'b0);
        chk("t6_adr", adr_o, 32'h0);
        chk("t6_instr", fetch_instr_o, 32'h0);
        rst = 1'b0; ack_i = 1'b1; dat_i = 32'hBAD0_BAD0;
        tick();
        chk1("t6_restart_stb", stb_o, 1'b1);
        chk("t6_restart_adr", adr_o, 32'h0);
        ack_i = 1'b1; dat_i = word_of(32'h0);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        tick();
        ack_i = 1'b0;
        chk1("t6_no_early", fetch_valid_o, 1'b0);
        tick();
        chk1("t6_valid_after", fetch_valid_o, 1'b1);
        chk("t6_stray_ignored", fetch_instr_o, word_of(32'h0));
        fetch_req_i = 1'b0;

        chk("adr_hi_zero", 32'(hi_bad), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
